// File: rtl/mips_pkg.sv
// ============================================================================
// Module  : mips_pkg
// Brief   : Shared constants and prefetch FIFO entry type for the fetch path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;
  localparam int          INSTR_W          = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fifo_entry_t;
endpackage

`default_nettype wire

// File: rtl/prefetch_fifo.sv
// ============================================================================
// Module  : prefetch_fifo
// Brief   : Synchronous DEPTH-entry FIFO; clear overrides push and pop.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prefetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic             i_pop,
  input  fifo_entry_t      i_data,
  output fifo_entry_t      o_data,
  output logic [CNT_W-1:0] o_count
);
  localparam int PTR_W = $clog2(DEPTH);

  fifo_entry_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

`default_nettype wire

// File: rtl/imem_prefetch_unit.sv
// ============================================================================
// Module  : imem_prefetch_unit
// Brief   : Instruction memory + PC sequencer + prefetch FIFO.
//           Optional PREFETCH_STATS_EN adds fetch_count / flush_count outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_prefetch_unit
  import mips_pkg::*;
#(
  parameter int          ADDR_W   = 12,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init_mode,
  input  logic                       write_enable,
  input  logic [ADDR_W-1:0]          init_address,
  input  logic [INSTR_W-1:0]         init_instruction,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  input  logic                       deq_ready,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [INSTR_W-1:0]         out_instruction,
  output logic [31:0]                fetch_pc,
`ifdef PREFETCH_STATS_EN
  output logic [31:0]                fetch_count,
  output logic [31:0]                flush_count,
`endif
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int               CNT_W       = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]   c_DEPTH_LVL = (CNT_W + 1)'(DEPTH);

  logic [INSTR_W-1:0] r_imem [2**ADDR_W];
  logic [INSTR_W-1:0] r_rd_data;
  logic [31:0]        r_rd_pc;
  logic [31:0]        r_fetch_pc;
  logic               r_inflight;
  logic               r_started;

  logic [CNT_W:0]     w_level;
  logic               w_issue;
  logic               w_flush;
  logic               w_push;
  logic               w_pop;
  logic               w_head_valid;
  logic [ADDR_W-1:0]  w_rd_idx;
  fifo_entry_t        w_push_entry;
  fifo_entry_t        w_head;

  // r_started holds off the first fetch until the cycle after reset release.
  assign w_level      = {1'b0, occupancy} + (CNT_W + 1)'(r_inflight);
  assign w_issue      = r_started && !init_mode && !redirect_valid && (w_level < c_DEPTH_LVL);
  assign w_flush      = init_mode || redirect_valid;
  assign w_push       = r_inflight && !w_flush;
  assign w_head_valid = (occupancy != '0);
  assign w_pop        = w_head_valid && deq_ready;
  assign w_rd_idx     = r_fetch_pc[ADDR_W+1:2];
  assign w_push_entry = '{pc: r_rd_pc, instr: r_rd_data};

  always_ff @(posedge clk) begin
    if (init_mode && write_enable) begin
      r_imem[init_address] <= init_instruction;
    end
    if (w_issue) begin
      r_rd_data <= r_imem[w_rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_rd_pc    <= '0;
      r_inflight <= 1'b0;
      r_started  <= 1'b0;
    end else begin
      r_started  <= 1'b1;
      r_inflight <= w_issue;
      if (w_issue) r_rd_pc <= r_fetch_pc;
      if (init_mode)           r_fetch_pc <= RESET_PC;
      else if (redirect_valid) r_fetch_pc <= redirect_pc;
      else if (w_issue)        r_fetch_pc <= r_fetch_pc + PC_STEP;
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_entry),
    .o_data  (w_head),
    .o_count (occupancy)
  );

  assign out_valid       = w_head_valid;
  assign out_pc          = w_head_valid ? w_head.pc    : '0;
  assign out_instruction = w_head_valid ? w_head.instr : '0;
  assign fetch_pc        = r_fetch_pc;

`ifdef PREFETCH_STATS_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_count <= '0;
      r_flush_count <= '0;
    end else if (!init_mode) begin
      if (w_issue)        r_fetch_count <= r_fetch_count + 32'd1;
      if (redirect_valid) r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign flush_count = r_flush_count;
`endif
endmodule

`default_nettype wire
